// File: rtl/ratio_det_pkg.sv
// rtl/ratio_det_pkg.sv - shared types and default constants for the divider ratio detector
// Purpose: FSM state encoding and default parameter values used by the detector and its bus interface.
// Ports: none (package).
package ratio_det_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_e;

   localparam int CNT_W_DEF      = 8;
   localparam int LOCK_COUNT_DEF = 4;
   localparam int TOL_DEF        = 0;
   localparam int TIMEOUT_DEF    = 200;

endpackage

// File: rtl/divider_ratio_detector_if.sv
// rtl/divider_ratio_detector_if.sv - signal/status bundle of the divider ratio detector
// Purpose: groups the divided input and the measurement/status outputs.
// Signals: sig_in (divided clock, async), half_period (last half-period in clk cycles),
//          period_valid (one-cycle update pulse), locked (stable measurements), lost (sticky timeout).
// Modports: master drives sig_in and observes status; slave is the detector side.
interface divider_ratio_detector_if
   import ratio_det_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             sig_in;
   logic [CNT_W-1:0] half_period;
   logic             period_valid;
   logic             locked;
   logic             lost;

   modport master (output sig_in, input half_period, period_valid, locked, lost);
   modport slave  (input sig_in, output half_period, period_valid, locked, lost);
endinterface

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer plus history flop, any-edge detector
// Purpose: brings an asynchronous level into the clk domain and flags both edges.
// Ports: clk, reset (async, active-high), sig_i (async level), edge_o (one-cycle edge flag).
module sync_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic edge_o
);
   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sig_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // s1 may be metastable; only the settled s2/s3 pair is compared.
   assign edge_o = s2_q ^ s3_q;
endmodule

// File: rtl/divider_ratio_detector.sv
// rtl/divider_ratio_detector.sv - recovers the half-period of a divided clock and tracks lock/loss
// Purpose: counts clk cycles between edges of sig_in, reports each interval, declares lock after
//          LOCK_COUNT consecutive matching intervals and flags a lost signal after TIMEOUT cycles.
// Ports: clk (rising edge), reset (async, active-high), bus (slave side of divider_ratio_detector_if).
module divider_ratio_detector
   import ratio_det_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int LOCK_COUNT = LOCK_COUNT_DEF,
   parameter int TOL        = TOL_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   divider_ratio_detector_if.slave   bus
);
   localparam int               MC_W      = $clog2(LOCK_COUNT + 1);
   localparam logic [MC_W-1:0]  LOCK_C    = MC_W'(LOCK_COUNT);
   localparam logic [MC_W-1:0]  ONE_C     = MC_W'(1);
   localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic             edge_w;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_e           state_q;
   logic [MC_W-1:0]  match_q;
   logic [CNT_W-1:0] prev_q;
   logic [CNT_W-1:0] half_q;
   logic             pv_q;
   logic             locked_q;
   logic             lost_q;

   logic [CNT_W-1:0] diff_w;
   logic             within_tol_w;
   logic [MC_W-1:0]  match_inc_w;
   logic             timeout_w;

   sync_edge_det u_sync (
      .clk    (clk),
      .reset  (reset),
      .sig_i  (bus.sig_in),
      .edge_o (edge_w)
   );

   // Interval counter: restarts at 1 on every edge so that its value at the
   // next edge equals the number of clk cycles between the two edges.
   always_comb begin
      cnt_d = cnt_q;
      if (edge_w) begin
         cnt_d = CNT_W'(1);
      end else if (!(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign diff_w       = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
   assign within_tol_w = (diff_w <= TOL_C);
   // match_q == 0 only for the first measurement after entering TRACK from IDLE.
   assign match_inc_w  = ((match_q == '0) || !within_tol_w) ? ONE_C : (match_q + ONE_C);
   assign timeout_w    = (state_q != IDLE) && (cnt_q >= TIMEOUT_C);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         match_q  <= '0;
         prev_q   <= '0;
         half_q   <= '0;
         pv_q     <= 1'b0;
         locked_q <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         pv_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // First edge only starts the interval; the partial one is discarded.
               if (edge_w) begin
                  state_q <= TRACK;
               end
            end
            TRACK, LOCKED: begin
               // An edge takes priority over a coincident timeout.
               if (edge_w) begin
                  half_q <= cnt_q;
                  pv_q   <= 1'b1;
                  lost_q <= 1'b0;
                  prev_q <= cnt_q;
                  if (state_q == LOCKED) begin
                     if (within_tol_w) begin
                        match_q <= LOCK_C;
                     end else begin
                        state_q  <= TRACK;
                        locked_q <= 1'b0;
                        match_q  <= ONE_C;
                     end
                  end else begin
                     match_q <= match_inc_w;
                     if (match_inc_w == LOCK_C) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end
               end else if (timeout_w) begin
                  state_q  <= IDLE;
                  locked_q <= 1'b0;
                  lost_q   <= 1'b1;
                  match_q  <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.half_period  = half_q;
   assign bus.period_valid = pv_q;
   assign bus.locked       = locked_q;
   assign bus.lost         = lost_q;
endmodule

// File: tb/tb_divider_ratio_detector.sv
// tb/tb_divider_ratio_detector.sv - self-checking bench for divider_ratio_detector
module tb_divider_ratio_detector;
   localparam int LOCK_COUNT = 4;
   localparam int TIMEOUT    = 200;
   localparam int LAT        = 3;

   logic clk;
   logic reset;
   logic sig;

   divider_ratio_detector_if bus0 ();
   divider_ratio_detector_if bus1 ();

   divider_ratio_detector #(.TOL(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   divider_ratio_detector #(.TOL(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors;
   int miscompares;
   int ncyc;
   int last_tog;
   int tol_of  [2];
   bit active  [2];
   int exp_hp  [2];
   bit exp_pv  [2];
   bit exp_lk  [2];
   bit exp_lost[2];
   int mq      [2][$];
   int ev_due  [2][$];
   int ev_hp   [2][$];
   bit ev_lk   [2][$];

   function automatic int iabs(int x);
      return (x < 0) ? -x : x;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_outputs(string when);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s d%0d half_period", when, d),
             (d == 0) ? 32'(bus0.half_period) : 32'(bus1.half_period), exp_hp[d]);
         chk($sformatf("%s d%0d period_valid", when, d),
             (d == 0) ? 32'(bus0.period_valid) : 32'(bus1.period_valid), 32'(exp_pv[d]));
         chk($sformatf("%s d%0d locked", when, d),
             (d == 0) ? 32'(bus0.locked) : 32'(bus1.locked), 32'(exp_lk[d]));
         chk($sformatf("%s d%0d lost", when, d),
             (d == 0) ? 32'(bus0.lost) : 32'(bus1.lost), 32'(exp_lost[d]));
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         active[d]   = 1'b0;
         exp_hp[d]   = 0;
         exp_pv[d]   = 1'b0;
         exp_lk[d]   = 1'b0;
         exp_lost[d] = 1'b0;
         mq[d].delete();
         ev_due[d].delete();
         ev_hp[d].delete();
         ev_lk[d].delete();
      end
   endtask

   // Advance one clk and compare against the expectation for this cycle.
   task automatic step();
      @(negedge clk);
      ncyc++;
      for (int d = 0; d < 2; d++) begin
         exp_pv[d] = 1'b0;
         if (ev_due[d].size() > 0 && ev_due[d][0] == ncyc) begin
            void'(ev_due[d].pop_front());
            exp_hp[d]   = ev_hp[d].pop_front();
            exp_lk[d]   = ev_lk[d].pop_front();
            exp_lost[d] = 1'b0;
            exp_pv[d]   = 1'b1;
         end
         if (active[d] && ncyc == last_tog + TIMEOUT + LAT) begin
            active[d]   = 1'b0;
            exp_lk[d]   = 1'b0;
            exp_lost[d] = 1'b1;
            mq[d].delete();
         end
      end
      check_outputs("cycle");
   endtask

   // Toggle sig_in now; an interval is measured if the signal is being tracked
   // and the gap fits in the timeout, and lock means the latest LOCK_COUNT
   // measurements form a chain of neighbours within tolerance.
   task automatic toggle();
      for (int d = 0; d < 2; d++) begin
         int meas;
         int run;
         meas = ncyc - last_tog;
         if (active[d] && meas <= TIMEOUT) begin
            mq[d].push_back(meas);
            if (mq[d].size() > 8) void'(mq[d].pop_front());
            run = 1;
            for (int i = mq[d].size() - 1; i > 0; i--) begin
               if (iabs(mq[d][i] - mq[d][i-1]) <= tol_of[d]) run++;
               else break;
            end
            ev_due[d].push_back(ncyc + LAT);
            ev_hp[d].push_back(meas);
            ev_lk[d].push_back(run >= LOCK_COUNT);
         end else begin
            active[d] = 1'b1;
            mq[d].delete();
         end
      end
      last_tog    = ncyc;
      sig         = ~sig;
      bus0.sig_in = sig;
      bus1.sig_in = sig;
   endtask

   task automatic gap(int n);
      repeat (n) step();
      toggle();
   endtask

   task automatic run_ratio(int n, int count);
      for (int k = 0; k < count; k++) gap(n);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      ncyc        = 0;
      last_tog    = 0;
      tol_of[0]   = 0;
      tol_of[1]   = 1;
      model_clear();
      sig         = 1'b0;
      bus0.sig_in = 1'b0;
      bus1.sig_in = 1'b0;
      reset       = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      repeat (2) step();

      // Basic lock at 5, then ratio change to 9.
      run_ratio(5, 8);
      run_ratio(9, 6);

      // Lock at 7, then silence long enough to time out, then resume.
      run_ratio(7, 6);
      gap(250);
      gap(7);
      repeat (12) step();

      // Gap exactly equal to the timeout is still a measurement.
      gap(5);
      gap(TIMEOUT);

      // Tolerance sequence: locks only with TOL=1.
      gap(10);
      gap(11);
      gap(10);
      gap(9);
      gap(10);

      // Fastest input: toggle every clk.
      run_ratio(1, 8);
      run_ratio(6, 6);

      // Asynchronous reset between clk edges while locked.
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      check_outputs("async_reset");
      sig         = 1'b0;
      bus0.sig_in = 1'b0;
      bus1.sig_in = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      gap(4);
      run_ratio(6, 6);

      // Randomized ratios with occasional one-cycle jitter.
      for (int r = 0; r < 6; r++) begin
         int base;
         base = int'($urandom_range(2, 30));
         for (int k = 0; k < 7; k++) begin
            gap(base + (($urandom_range(0, 3) == 0) ? 1 : 0));
         end
      end
      repeat (10) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
